muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide unit. It sits between the register file read ports and the register file write port.
- Consumes the two register read values plus the destination index from decode.
- After a multi-cycle computation, drives a one-cycle write request (writeReg, writeData, writeEnable) toward the RegisterFile write port.
- Stalls the core through busy while computing.

Parameters:
XLEN, 32, operand/result width (only 32 is verified).
REG_AW, 5, register index width.

Ports:
clk  input  1  core clock; all state updates on rising edge.
rst  input  1  asynchronous, active-low reset.
start  input  1  request pulse; accepted only in IDLE.
funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
operandA  input  XLEN  rs1 value (readData1).
operandB  input  XLEN  rs2 value (readData2).
rdIn  input  REG_AW  destination register index.
busy  output  1  high while an operation is in flight.
done  output  1  one-cycle completion pulse.
writeReg  output  REG_AW  captured rdIn, valid while done.
writeData  output  XLEN  result, valid while done.
writeEnable  output  1  done AND (captured rd != 0).

Behaviour:
- Reset (rst low, async): state=IDLE, busy=0, done=0, writeEnable=0, writeData=0, writeReg=0, counter=0, internal operands=0. Reset mid-operation aborts it; no writeback is produced.
- States:
  - IDLE: busy=0.
  - CALC: busy=1, 32 iterations.
  - FIX: busy=1, sign correction and result select.
- Accept: rising edge with state==IDLE and start==1. funct3, operands and rdIn are captured; later input changes are ignored.
- start while busy=1 is ignored (not queued).
- Normal path:
  - Accept edge (E0) → CALC with counter=0.
  - Edges E1..E32: one iteration each; at E32 → FIX.
  - E33 → IDLE with done=1 and writeData/writeReg loaded.
  - done is high for exactly the cycle after E33.
- Fast path (divide ops only): if divisor==0, or signed DIV/REM with A=0x80000000 and B=0xFFFFFFFF, E0 goes straight to FIX and done is high in the cycle after E1.
- Multiply:
  - Shift-add on magnitudes; sign applied in FIX via two's complement of the 64-bit product.
  - MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
  - Signedness:
    - MULH: both operands signed.
    - MULHSU: A signed, B unsigned.
    - MULHU: both unsigned.
- Divide:
  - Restoring divide on magnitudes.
  - Quotient sign = signA XOR signB (signed ops only).
  - Remainder sign = signA.
  - Rounding toward zero.
- Special results:
  - Divide by zero: DIV/DIVU = 0xFFFFFFFF, REM/REMU = operandA.
  - Overflow case: DIV = 0x80000000, REM = 0.
- done and busy are mutually exclusive: busy falls at the same edge done rises.
- A new start is accepted in the same cycle done is high, allowing back-to-back operations with no bubble.
- rdIn==0: done still pulses and writeData is still valid, but writeEnable=0.
- writeData/writeReg hold their last values after done falls; writeEnable and done return to 0.

Test Plan:
1. Reset, then MUL A=7, B=0xFFFFFFFD (-3), rd=5 → done exactly 33 edges after accept, writeData=0xFFFFFFEB, writeReg=5, writeEnable=1; busy high for 33 cycles.
2. MULH A=B=0x80000000 → 0x40000000; MULHU A=B=0xFFFFFFFF → 0xFFFFFFFE; MULHSU A=0xFFFFFFFF, B=0xFFFFFFFF → 0xFFFFFFFF.
3. DIV A=0xFFFFFFF9 (-7), B=2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
4. DIVU A=0x1234, B=0 → 0xFFFFFFFF with done after 2 edges; REM A=0x1234, B=0 → 0x1234; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same operands → 0.
5. Control boundaries:
   - start pulsed mid-CALC → ignored; exactly one done.
   - start held high through done → second operation accepted in the done cycle.
   - rd=0 → done=1 with writeEnable=0.
6. rst driven low at CALC iteration 10 → busy/done/writeEnable=0 immediately (asynchronously); no done after release; next operation (MUL 3×4 → 12) completes correctly.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply and restoring
// divide on operand magnitudes, with sign fix-up and a one-cycle writeback pulse.
module muldiv_unit #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   operandA,
  input  logic [XLEN-1:0]   operandB,
  input  logic [REG_AW-1:0] rdIn,
  output logic              busy,
  output logic              done,
  output logic [REG_AW-1:0] writeReg,
  output logic [XLEN-1:0]   writeData,
  output logic              writeEnable
);
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]     CNT_LAST = CW'(XLEN - 1);
  localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
  localparam logic [XLEN-1:0]   ZERO     = {XLEN{1'b0}};
  localparam logic [XLEN-1:0]   ONES     = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]   MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [REG_AW-1:0] RD_ZERO  = {REG_AW{1'b0}};

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

  state_t              state_r, state_nx;
  logic [2:0]          op_r;
  logic [REG_AW-1:0]   rd_r;
  logic [XLEN-1:0]     b_mag_r;
  logic [2*XLEN-1:0]   acc_r;
  logic [CW-1:0]       cnt_r;
  logic                neg_q_r, neg_rem_r, fast_r;

  logic                accept_s, a_neg_s, b_neg_s, div_zero_s, ovf_s, fast_s;
  logic [XLEN-1:0]     fast_res_s, result_s, quo_s, rem_s;
  logic [XLEN:0]       mul_sum_s, div_trial_s;
  logic [2*XLEN-1:0]   mul_next_s, div_next_s, prod_s;

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cond_neg_wide(input logic [2*XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  assign accept_s   = (state_r == IDLE) && start;
  assign div_zero_s = (operandB == ZERO);
  assign ovf_s      = ~funct3[0] && (operandA == MIN_NEG) && (operandB == ONES);
  assign fast_s     = funct3[2] && (div_zero_s || ovf_s);

  // Operand signedness per funct3: MULH both, MULHSU A only, DIV/REM both.
  always_comb begin
    a_neg_s = 1'b0;
    b_neg_s = 1'b0;
    case (funct3)
      3'b001, 3'b100, 3'b110: begin
        a_neg_s = operandA[XLEN-1];
        b_neg_s = operandB[XLEN-1];
      end
      3'b010: a_neg_s = operandA[XLEN-1];
      default: begin
        a_neg_s = 1'b0;
        b_neg_s = 1'b0;
      end
    endcase
  end

  // Special divide results, resolved at accept time.
  always_comb begin
    fast_res_s = ZERO;
    if (div_zero_s) begin
      fast_res_s = funct3[1] ? operandA : ONES;
    end else begin
      fast_res_s = funct3[1] ? ZERO : MIN_NEG;
    end
  end

  // acc holds {product_hi, multiplier} for multiply and {remainder, quotient} for divide.
  assign mul_sum_s   = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, b_mag_r} : {1'b0, ZERO});
  assign mul_next_s  = {mul_sum_s, acc_r[XLEN-1:1]};
  assign div_trial_s = acc_r[2*XLEN-1:XLEN-1] - {1'b0, b_mag_r};
  assign div_next_s  = div_trial_s[XLEN] ? {acc_r[2*XLEN-2:0], 1'b0}
                                         : {div_trial_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};

  assign prod_s = cond_neg_wide(acc_r, neg_q_r);
  assign quo_s  = cond_neg(acc_r[XLEN-1:0], neg_q_r);
  assign rem_s  = cond_neg(acc_r[2*XLEN-1:XLEN], neg_rem_r);

  // Final result select in FIX.
  always_comb begin
    result_s = ZERO;
    if (fast_r) begin
      result_s = acc_r[XLEN-1:0];
    end else begin
      case (op_r)
        3'b000:                 result_s = prod_s[XLEN-1:0];
        3'b001, 3'b010, 3'b011: result_s = prod_s[2*XLEN-1:XLEN];
        3'b100, 3'b101:         result_s = quo_s;
        3'b110, 3'b111:         result_s = rem_s;
        default:                result_s = ZERO;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= IDLE;
    else      state_r <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nx = fast_s ? FIX : CALC;
        else          state_nx = IDLE;
      end
      CALC: begin
        if (cnt_r == CNT_LAST) state_nx = FIX;
        else                   state_nx = CALC;
      end
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath, operand capture and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_r        <= 3'b000;
      rd_r        <= RD_ZERO;
      b_mag_r     <= ZERO;
      acc_r       <= {ZERO, ZERO};
      cnt_r       <= {CW{1'b0}};
      neg_q_r     <= 1'b0;
      neg_rem_r   <= 1'b0;
      fast_r      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      writeEnable <= 1'b0;
      writeData   <= ZERO;
      writeReg    <= RD_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          done        <= 1'b0;
          writeEnable <= 1'b0;
          if (accept_s) begin
            op_r      <= funct3;
            rd_r      <= rdIn;
            cnt_r     <= {CW{1'b0}};
            busy      <= 1'b1;
            fast_r    <= fast_s;
            neg_q_r   <= a_neg_s ^ b_neg_s;
            neg_rem_r <= a_neg_s;
            b_mag_r   <= cond_neg(operandB, b_neg_s);
            acc_r     <= {ZERO, fast_s ? fast_res_s : cond_neg(operandA, a_neg_s)};
          end
        end
        CALC: begin
          acc_r <= op_r[2] ? div_next_s : mul_next_s;
          cnt_r <= cnt_r + CNT_ONE;
        end
        FIX: begin
          busy        <= 1'b0;
          done        <= 1'b1;
          writeEnable <= (rd_r != RD_ZERO);
          writeData   <= result_s;
          writeReg    <= rd_r;
        end
        default: begin
          busy <= 1'b0;
          done <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: arithmetic results, latencies,
// special divide cases, control boundaries and asynchronous abort.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] operandA = 32'd0;
  logic [31:0] operandB = 32'd0;
  logic [4:0]  rdIn = 5'd0;
  logic        busy, done, writeEnable;
  logic [4:0]  writeReg;
  logic [31:0] writeData;

  int total = 0;
  int bad = 0;
  int busy_cnt = 0;

  muldiv_unit #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .operandA(operandA), .operandB(operandB), .rdIn(rdIn),
    .busy(busy), .done(done), .writeReg(writeReg),
    .writeData(writeData), .writeEnable(writeEnable)
  );

  always #5 clk = ~clk;

  // Present an operation before a rising edge; returns #1 after that accept edge.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit hold);
    @(negedge clk);
    funct3 = f; operandA = a; operandB = b; rdIn = rd; start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    busy_cnt = busy ? 1 : 0;
  endtask

  task automatic wait_done(output int n, output bit ok);
    n = 0; ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      n++;
      if (done) begin ok = 1'b1; break; end
      if (busy) busy_cnt++;
    end
    if (!ok) begin total++; bad++; $display("FAIL wait_done: no done within %0d edges", n); end
  endtask

  task automatic count_dones(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (done) cnt++;
    end
  endtask

  task automatic test_reset();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (writeEnable !== 1'b0) begin bad++; $display("FAIL reset_we: got %b want 0", writeEnable); end
    total++; if (writeData !== 32'h0) begin bad++; $display("FAIL reset_data: got %h want 0", writeData); end
    total++; if (writeReg !== 5'd0) begin bad++; $display("FAIL reset_reg: got %0d want 0", writeReg); end
  endtask

  task automatic test_mul_basic();
    int n; bit ok;
    issue(3'b000, 32'd7, 32'hFFFFFFFD, 5'd5, 1'b0);
    wait_done(n, ok);
    total++; if (n != 33) begin bad++; $display("FAIL mul_latency: got %0d want 33", n); end
    total++; if (busy_cnt != 33) begin bad++; $display("FAIL mul_busy_cycles: got %0d want 33", busy_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mul_busy_at_done: got %b want 0", busy); end
    total++; if (writeData !== 32'hFFFFFFEB) begin bad++; $display("FAIL mul_data: got %h want ffffffeb", writeData); end
    total++; if (writeReg !== 5'd5) begin bad++; $display("FAIL mul_reg: got %0d want 5", writeReg); end
    total++; if (writeEnable !== 1'b1) begin bad++; $display("FAIL mul_we: got %b want 1", writeEnable); end
    @(posedge clk); #1;
    total++; if (done !== 1'b0 || writeEnable !== 1'b0) begin bad++; $display("FAIL mul_pulse_end: done=%b we=%b want 0 0", done, writeEnable); end
    total++; if (writeData !== 32'hFFFFFFEB || writeReg !== 5'd5) begin bad++; $display("FAIL mul_hold: got %h/%0d want ffffffeb/5", writeData, writeReg); end
  endtask

  task automatic test_mul_high();
    logic [2:0]  fs [3] = '{3'b001, 3'b011, 3'b010};
    logic [31:0] as [3] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] bs [3] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] ex [3] = '{32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF};
    int n; bit ok;
    for (int i = 0; i < 3; i++) begin
      issue(fs[i], as[i], bs[i], 5'd9, 1'b0);
      wait_done(n, ok);
      total++; if (writeData !== ex[i]) begin bad++; $display("FAIL mulhi_%0d: got %h want %h", i, writeData, ex[i]); end
    end
  endtask

  task automatic test_divide();
    logic [2:0]  fs [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
    logic [31:0] as [4] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
    logic [31:0] bs [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] ex [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
    int n; bit ok;
    for (int i = 0; i < 4; i++) begin
      issue(fs[i], as[i], bs[i], 5'd10, 1'b0);
      wait_done(n, ok);
      total++; if (writeData !== ex[i]) begin bad++; $display("FAIL div_%0d: got %h want %h", i, writeData, ex[i]); end
      total++; if (n != 33) begin bad++; $display("FAIL div_latency_%0d: got %0d want 33", i, n); end
    end
  endtask

  task automatic test_special();
    logic [2:0]  fs [4] = '{3'b101, 3'b110, 3'b100, 3'b110};
    logic [31:0] as [4] = '{32'h1234, 32'h1234, 32'h80000000, 32'h80000000};
    logic [31:0] bs [4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] ex [4] = '{32'hFFFFFFFF, 32'h1234, 32'h80000000, 32'h0};
    int n; bit ok;
    for (int i = 0; i < 4; i++) begin
      issue(fs[i], as[i], bs[i], 5'd11, 1'b0);
      wait_done(n, ok);
      total++; if (writeData !== ex[i]) begin bad++; $display("FAIL special_%0d: got %h want %h", i, writeData, ex[i]); end
      total++; if (n != 1) begin bad++; $display("FAIL special_latency_%0d: got %0d want 1", i, n); end
    end
  endtask

  task automatic test_ignore_start();
    int n, extra; bit ok;
    issue(3'b000, 32'd5, 32'd5, 5'd6, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    funct3 = 3'b101; operandA = 32'd9; operandB = 32'd3; rdIn = 5'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n, ok);
    total++; if (n != 23) begin bad++; $display("FAIL ignore_latency: got %0d want 23", n); end
    total++; if (writeData !== 32'd25 || writeReg !== 5'd6) begin bad++; $display("FAIL ignore_result: got %h/%0d want 19/6", writeData, writeReg); end
    count_dones(40, extra);
    total++; if (extra != 0) begin bad++; $display("FAIL ignore_extra_done: got %0d want 0", extra); end
  endtask

  task automatic test_back_to_back();
    int n; bit ok;
    issue(3'b000, 32'd6, 32'd7, 5'd3, 1'b1);
    funct3 = 3'b101; operandA = 32'd100; operandB = 32'd7; rdIn = 5'd4;
    wait_done(n, ok);
    total++; if (writeData !== 32'd42 || writeReg !== 5'd3) begin bad++; $display("FAIL b2b_first: got %h/%0d want 2a/3", writeData, writeReg); end
    @(posedge clk); #1;
    start = 1'b0;
    total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL b2b_accept: busy=%b done=%b want 1 0", busy, done); end
    wait_done(n, ok);
    total++; if (n != 33) begin bad++; $display("FAIL b2b_latency: got %0d want 33", n); end
    total++; if (writeData !== 32'd14 || writeReg !== 5'd4) begin bad++; $display("FAIL b2b_second: got %h/%0d want e/4", writeData, writeReg); end
  endtask

  task automatic test_rd_zero();
    int n; bit ok;
    issue(3'b000, 32'd2, 32'd3, 5'd0, 1'b0);
    wait_done(n, ok);
    total++; if (done !== 1'b1 || writeEnable !== 1'b0) begin bad++; $display("FAIL rd0_we: done=%b we=%b want 1 0", done, writeEnable); end
    total++; if (writeData !== 32'd6) begin bad++; $display("FAIL rd0_data: got %h want 6", writeData); end
  endtask

  task automatic test_reset_abort();
    int n, extra; bit ok;
    issue(3'b101, 32'd1000, 32'd3, 5'd12, 1'b0);
    repeat (9) @(posedge clk);
    #2; rst = 1'b0; #1;
    total++; if (busy !== 1'b0 || done !== 1'b0 || writeEnable !== 1'b0) begin bad++; $display("FAIL abort_async: busy=%b done=%b we=%b want 0 0 0", busy, done, writeEnable); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    count_dones(40, extra);
    total++; if (extra != 0) begin bad++; $display("FAIL abort_no_done: got %0d want 0", extra); end
    total++; if (writeData !== 32'h0) begin bad++; $display("FAIL abort_data_cleared: got %h want 0", writeData); end
    issue(3'b000, 32'd3, 32'd4, 5'd1, 1'b0);
    wait_done(n, ok);
    total++; if (writeData !== 32'd12 || n != 33) begin bad++; $display("FAIL abort_recover: got %h in %0d want c in 33", writeData, n); end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b1;
    test_mul_basic();
    test_mul_high();
    test_divide();
    test_special();
    test_ignore_start();
    test_back_to_back();
    test_rd_zero();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
